// File: rtl/conv1d_weight_loader.sv
// conv1d_weight_loader
// Collects k weight words from a valid/ready stream into a staging buffer,
// then writes the whole packed vector to w with a one-cycle w_en/done strobe.
// An abort during collection discards the partial load and leaves w untouched.
module conv1d_weight_loader #(
    parameter int k  = 15,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [DW-1:0]   s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [k*DW-1:0] w,
    output logic            w_en,
    output logic            done,
    output logic            busy
);
    // One extra counter bit lets the count reach k without wrapping.
    localparam int            CW   = $clog2(k) + 1;
    localparam logic [CW-1:0] LAST = CW'(k - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_s_ready;
    logic [DW-1:0]   r_stage [k];
    logic [k*DW-1:0] r_w;
    logic            r_w_en;
    logic            r_done;

    logic            w_hs;
    logic            w_wr;
    logic            w_commit;

    assign w_hs = s_valid & r_s_ready;

    // Next-state decode; abort outranks a simultaneous handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_hs) begin
                    w_wr = 1'b1;
                    if (r_cnt == LAST) begin
                        w_state_nxt = COMMIT;
                    end
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register, word counter and registered ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_s_ready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= (w_state_nxt == FILL);
            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (w_wr) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Staging buffer: each accepted word lands in the slot selected by the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < k; i++) begin
                r_stage[i] <= '0;
            end
        end else if (w_wr) begin
            for (int i = 0; i < k; i++) begin
                if (r_cnt == CW'(i)) begin
                    r_stage[i] <= s_data;
                end
            end
        end
    end

    // Output register: w only changes on a completed load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w    <= '0;
            r_w_en <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_w_en <= w_commit;
            r_done <= w_commit;
            if (w_commit) begin
                for (int i = 0; i < k; i++) begin
                    r_w[i*DW +: DW] <= r_stage[i];
                end
            end
        end
    end

    assign s_ready = r_s_ready;
    assign w       = r_w;
    assign w_en    = r_w_en;
    assign done    = r_done;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_conv1d_weight_loader.sv
// Bench for conv1d_weight_loader: a k=15 instance driven by randomized and
// scripted loads, and a k=1 instance driven from a vector table.
module tb_conv1d_weight_loader;
    localparam int K  = 15;
    localparam int DW = 16;

    logic            clk;
    logic            rst;

    logic            start15, abort15, s_valid15;
    logic [DW-1:0]   s_data15;
    logic            s_ready15, w_en15, done15, busy15;
    logic [K*DW-1:0] w15;

    logic            start1, abort1, s_valid1;
    logic [DW-1:0]   s_data1;
    logic            s_ready1, w_en1, done1, busy1;
    logic [DW-1:0]   w1;

    int total;
    int bad;
    logic [K*DW-1:0] exp_w;

    conv1d_weight_loader #(.k(K), .DW(DW)) u15 (
        .clk(clk), .rst(rst), .start(start15), .abort(abort15),
        .s_data(s_data15), .s_valid(s_valid15), .s_ready(s_ready15),
        .w(w15), .w_en(w_en15), .done(done15), .busy(busy15)
    );

    conv1d_weight_loader #(.k(1), .DW(DW)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
        .w(w1), .w_en(w_en1), .done(done1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task chk(input string name, input logic [K*DW-1:0] act, input logic [K*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One k=15 load with optional bubbles, abort, start noise and a restart on the w_en cycle.
    task automatic load15(input int abort_at, input bit bubbles, input bit start_noise,
                          input bit seq_data, input logic [DW-1:0] base, input bit restart);
        logic [DW-1:0]   d [K];
        logic [K*DW-1:0] pk;
        int idx;
        int guard;
        bit v;
        for (int i = 0; i < K; i++) begin
            d[i] = seq_data ? base + DW'(i) : DW'($urandom);
            pk[i*DW +: DW] = d[i];
        end
        start15 = 1'b1;
        cyc();
        start15 = 1'b0;
        chk("start_ready", s_ready15, 1);
        chk("start_busy", busy15, 1);
        idx = 0;
        guard = 0;
        while (idx < K) begin
            if (guard > 400) begin
                total++;
                bad++;
                $display("FAIL fill_timeout: got %0d words expected %0d", idx, K);
                s_valid15 = 1'b0;
                return;
            end
            guard++;
            v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid15 = v;
            s_data15  = v ? d[idx] : 16'hDEAD;
            start15   = start_noise && (idx == 5);
            if (idx == abort_at) begin
                abort15   = 1'b1;
                s_valid15 = 1'b1;
                s_data15  = 16'hBEEF;
                cyc();
                abort15   = 1'b0;
                s_valid15 = 1'b0;
                start15   = 1'b0;
                chk("abort_ready", s_ready15, 0);
                chk("abort_busy", busy15, 0);
                chk("abort_wen", w_en15, 0);
                for (int c = 0; c < 3; c++) begin
                    cyc();
                    chk("abort_no_wen", w_en15, 0);
                end
                chk("abort_w_kept", w15, exp_w);
                return;
            end
            cyc();
            if (v) idx++;
            chk("fill_ready", s_ready15, (idx < K) ? 1 : 0);
            chk("fill_wen", w_en15, 0);
            chk("fill_busy", busy15, 1);
        end
        // COMMIT cycle: stream stays valid and start may be pulsed, both must be ignored.
        s_valid15 = 1'b1;
        s_data15  = 16'hDEAD;
        start15   = start_noise;
        cyc();
        start15   = 1'b0;
        s_valid15 = 1'b0;
        exp_w = pk;
        chk("commit_wen", w_en15, 1);
        chk("commit_done", done15, 1);
        chk("commit_busy", busy15, 0);
        chk("commit_ready", s_ready15, 0);
        chk("commit_w", w15, exp_w);
        start15 = restart;
        cyc();
        start15 = 1'b0;
        chk("post_wen", w_en15, 0);
        chk("post_done", done15, 0);
        chk("post_w", w15, exp_w);
        chk("post_busy", busy15, restart ? 1 : 0);
        chk("post_ready", s_ready15, restart ? 1 : 0);
    endtask

    typedef struct {
        bit          st;
        bit          ab;
        bit          v;
        logic [15:0] d;
        bit          e_rdy;
        bit          e_wen;
        bit          e_busy;
        logic [15:0] e_w;
    } vec_t;

    vec_t tbl [11];

    initial begin
        total = 0;
        bad   = 0;
        exp_w = '0;
        rst = 1'b1;
        start15 = 1'b1; abort15 = 1'b0; s_valid15 = 1'b0; s_data15 = '0;
        start1  = 1'b1; abort1  = 1'b0; s_valid1  = 1'b0; s_data1  = '0;

        // Reset held across several edges with start high.
        repeat (3) cyc();
        chk("rst_w", w15, 0);
        chk("rst_wen", w_en15, 0);
        chk("rst_done", done15, 0);
        chk("rst_ready", s_ready15, 0);
        chk("rst_busy", busy15, 0);
        chk("rst_busy_k1", busy1, 0);
        chk("rst_w_k1", w1, 0);
        rst = 1'b0; start15 = 1'b0; start1 = 1'b0;
        cyc();
        chk("idle_busy", busy15, 0);

        // k=1 vector table: inputs before the edge, outputs after it.
        tbl[0]  = '{0, 0, 1, 16'h1111, 0, 0, 0, 16'h0000};
        tbl[1]  = '{1, 0, 0, 16'h2222, 1, 0, 1, 16'h0000};
        tbl[2]  = '{0, 0, 1, 16'hABCD, 0, 0, 1, 16'h0000};
        tbl[3]  = '{1, 0, 1, 16'h5555, 0, 1, 0, 16'hABCD};
        tbl[4]  = '{1, 0, 0, 16'h6666, 1, 0, 1, 16'hABCD};
        tbl[5]  = '{0, 1, 1, 16'h7777, 0, 0, 0, 16'hABCD};
        tbl[6]  = '{0, 0, 1, 16'h9999, 0, 0, 0, 16'hABCD};
        tbl[7]  = '{1, 0, 0, 16'h0000, 1, 0, 1, 16'hABCD};
        tbl[8]  = '{0, 0, 1, 16'h1234, 0, 0, 1, 16'hABCD};
        tbl[9]  = '{0, 0, 0, 16'h0000, 0, 1, 0, 16'h1234};
        tbl[10] = '{0, 0, 0, 16'h0000, 0, 0, 0, 16'h1234};
        for (int i = 0; i < 11; i++) begin
            start1 = tbl[i].st; abort1 = tbl[i].ab;
            s_valid1 = tbl[i].v; s_data1 = tbl[i].d;
            cyc();
            chk($sformatf("k1_ready[%0d]", i), s_ready1, tbl[i].e_rdy);
            chk($sformatf("k1_wen[%0d]", i), w_en1, tbl[i].e_wen);
            chk($sformatf("k1_done[%0d]", i), done1, tbl[i].e_wen);
            chk($sformatf("k1_busy[%0d]", i), busy1, tbl[i].e_busy);
            chk($sformatf("k1_w[%0d]", i), w1, tbl[i].e_w);
        end
        start1 = 1'b0; abort1 = 1'b0; s_valid1 = 1'b0;

        // Basic sequential load 0x0001..0x000F.
        load15(-1, 0, 0, 1, 16'h0001, 0);
        chk("basic_w_lo", w15[15:0], 16'h0001);
        chk("basic_w_hi", w15[239:224], 16'h000F);
        // Same data with bubbles and 0xDEAD on idle cycles.
        load15(-1, 1, 0, 1, 16'h0001, 0);
        // Load A, aborted B with valid on the abort cycle, then C.
        load15(-1, 0, 0, 1, 16'h0100, 0);
        load15(7, 0, 0, 1, 16'h0200, 0);
        load15(-1, 1, 0, 0, 16'h0000, 0);
        // Start pulsed at word 5 and in COMMIT, then restart on the w_en cycle.
        load15(-1, 0, 1, 0, 16'h0000, 1);
        load15(-1, 1, 0, 0, 16'h0000, 0);

        // Asynchronous reset after 5 words of a load.
        start15 = 1'b1;
        cyc();
        start15 = 1'b0;
        s_valid15 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data15 = DW'(16'h0A00 + i);
            cyc();
        end
        s_valid15 = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_w = '0;
        chk("arst_w", w15, exp_w);
        chk("arst_busy", busy15, 0);
        chk("arst_ready", s_ready15, 0);
        chk("arst_wen", w_en15, 0);
        chk("arst_done", done15, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // Randomized loads after reset.
        for (int n = 0; n < 4; n++) begin
            load15(-1, 1, n[0], 0, 16'h0000, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv1d_weight_loader.md
Name: conv1d_weight_loader

Overview:
Serial-to-parallel weight writer for conv1d. It accepts one weight word per handshake from a valid/ready stream and packs k words into a staging buffer. Once all k words are in, it presents the packed vector on w and pulses w_en for exactly one cycle. It sits between the weight memory/DMA stream and the w/w_en inputs of one conv1d instance.

Parameters:
k, 15, kernel size; number of words per load; must match the driven conv1d; legal range 1..65535.
DW, 16, weight word width; set to the project-wide `WIDTH_DATA.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request a new load; sampled only in IDLE.
abort  in  1  cancel the load in progress; honoured only in FILL.
s_data  in  DW  incoming weight word.
s_valid  in  1  s_data is valid.
s_ready  out  1  loader accepts s_data; registered.
w  out  k*DW  packed weights; word i occupies bits [(i+1)*DW-1 -: DW].
w_en  out  1  one-cycle write strobe to conv1d; registered.
done  out  1  one-cycle completion pulse; coincident with w_en.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, immediate on assertion):
  - state = IDLE; word counter = 0; staging buffer = 0.
  - w = 0, w_en = 0, done = 0, s_ready = 0, busy = 0.
- A handshake occurs on a rising edge where s_valid and s_ready are both 1. Only handshakes advance the counter.
- States:
  - IDLE: s_ready = 0.
    - start = 1 → FILL at the next edge; counter cleared; s_ready = 1 from that edge onward.
  - FILL: s_ready = 1.
    - On each handshake, s_data is written to staging slot cnt and cnt increments.
    - The k-th word is the first handshake with cnt == k-1. On that edge: state → COMMIT, s_ready → 0.
    - abort = 1 → IDLE at the next edge, s_ready → 0, staging buffer discarded, w unchanged, no w_en.
    - abort has priority over a simultaneous handshake; that word is dropped.
  - COMMIT: held for one cycle.
    - At the following edge: w ← staging buffer, w_en ← 1, done ← 1, state → IDLE.
    - At the next edge, w_en and done return to 0.
- Latency:
  - w_en and done are high for exactly one cycle, starting one clock after the edge that accepted the final word.
  - w is valid in the same cycle as w_en.
- w holds its value from commit until the next commit or reset. Partial or aborted loads never change w.
- start while busy (FILL or COMMIT) is ignored and not queued.
- start on the cycle w_en is high (state already IDLE) is accepted.
  - Minimum spacing between successive w_en pulses is k+2 cycles.
- s_valid without s_ready is not consumed. s_data may change freely while s_ready = 0.
- k = 1: the first handshake goes directly to COMMIT.
- Counter width is $clog2(k)+1 bits; the counter never wraps within a load.
- Reset asserted mid-FILL or in COMMIT: everything clears immediately, with no w_en and no done. The first load after reset behaves normally.

Test Plan:
- Reset check: assert rst with the clock running → w = 0, w_en = 0, done = 0, s_ready = 0, busy = 0. Hold start = 1 during reset → state stays IDLE.
- Basic load, k = 15, DW = 16: start, then stream words 0x0001..0x000F back-to-back → s_ready drops after the 15th handshake, w_en = done = 1 exactly one cycle later, w[15:0] = 0x0001, w[239:224] = 0x000F, w_en = 0 on the next cycle.
- Bubbles: same stream with s_valid toggled pseudo-randomly and s_data = 0xDEAD while s_valid = 0 → identical w; no 0xDEAD in any slot; w_en appears once.
- Abort: load A (words 0x0100..0x010E) completes. Start B and abort after 7 words, with s_valid high on the abort cycle → no w_en, w still equals A. Then a full load of C → w = C.
- Start while busy: pulse start again at word 5 and in COMMIT → exactly one w_en. Pulse start on the w_en cycle → FILL entered; the next load completes normally.
- Async reset mid-FILL after 5 words → outputs clear without waiting for a clock edge. A new load then produces a correct w. Repeat the basic load with k = 1: one word 0xABCD → w = 0xABCD, w_en one cycle after the handshake.
